io_uart_tx: RTL and testbench

//  Memory-mapped UART transmitter on the MMU IO port (io_addr/io_en/io_we/io_data_*).

---
 rtl/io_uart_tx.sv | 161 ++++++++++++++++
 tb/tb_io_uart_tx.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/io_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: bytes pushed to TXDATA queue in a FIFO and are shifted out LSB first.
// Write-to-start-bit latency 1 clock; a push into a full FIFO with no same-cycle pop is dropped and sets sticky overflow.
module io_uart_tx #(
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] DIV_RESET  = 16'd868
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  io_addr,
    input  logic        io_en,
    input  logic        io_we,
    input  logic [31:0] io_data_write,
    output logic [31:0] io_data_read,
    output logic        txd,
    output logic        tx_busy
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    logic [7:0]  mem_q [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count;
    logic        full, empty;
    logic        ovf_q, ovf_d;
    logic [15:0] div_q, div_d;
    state_t      state_q, state_d;
    logic [2:0]  bit_q, bit_d;
    logic [15:0] baud_q, baud_d;
    logic [7:0]  shift_q, shift_d;
    logic        txd_q, txd_d;
    logic        addr_ok, sel_txdata, sel_status, sel_div;
    logic        wr, rd, push_req, push, pop, baud_done;
    logic        unused_bits;

    assign count      = wr_ptr_q - rd_ptr_q;
    assign full       = (count == (AW+1)'(FIFO_DEPTH));
    assign empty      = (count == '0);
    assign addr_ok    = (io_addr[7:4] == 4'h0);
    assign sel_txdata = addr_ok && (io_addr[3:2] == 2'd0);
    assign sel_status = addr_ok && (io_addr[3:2] == 2'd1);
    assign sel_div    = addr_ok && (io_addr[3:2] == 2'd2);
    assign wr         = io_en & io_we;
    assign rd         = io_en & ~io_we;
    assign push_req   = wr & sel_txdata;
    assign push       = push_req & (~full | pop);
    assign baud_done  = (baud_q == 16'd0);
    assign tx_busy    = (state_q != S_IDLE);
    assign txd        = txd_q;
    assign unused_bits = ^{io_data_write[31:16], io_addr[1:0]};

    always_comb begin
        io_data_read = 32'h0;
        if (rd) begin
            if (sel_status)
                io_data_read = {16'h0, 8'(count), 4'h0, ovf_q, tx_busy, empty, full};
            else if (sel_div)
                io_data_read = {16'h0, div_q};
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
        ovf_d    = ovf_q;
        // A dropped push in the same cycle as a W1C keeps the flag set.
        if (push_req && !push)
            ovf_d = 1'b1;
        else if (wr && sel_status && io_data_write[3])
            ovf_d = 1'b0;
        div_d = div_q;
        if (wr && sel_div)
            div_d = (io_data_write[15:0] == 16'd0) ? 16'd1 : io_data_write[15:0];
    end

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        baud_d  = baud_q;
        shift_d = shift_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q[AW-1:0]];
                    baud_d  = div_q - 16'd1;
                    bit_d   = 3'd0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (baud_done) begin
                    baud_d  = div_q - 16'd1;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            S_DATA: begin
                if (baud_done) begin
                    baud_d  = div_q - 16'd1;
                    shift_d = shift_q >> 1;
                    if (bit_q == 3'd7)
                        state_d = S_STOP;
                    else
                        bit_d = bit_q + 3'd1;
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            default: begin
                if (!baud_done) begin
                    baud_d = baud_q - 16'd1;
                end else if (!empty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q[AW-1:0]];
                    baud_d  = div_q - 16'd1;
                    bit_d   = 3'd0;
                    state_d = S_START;
                end else begin
                    state_d = S_IDLE;
                end
            end
        endcase
        // txd is a register, so it is computed from where the FSM is heading.
        case (state_d)
            S_START: txd_d = 1'b0;
            S_DATA:  txd_d = shift_d[0];
            default: txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q[AW-1:0]] <= io_data_write[7:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
            div_q    <= DIV_RESET;
            state_q  <= S_IDLE;
            bit_q    <= 3'd0;
            baud_q   <= 16'd0;
            shift_q  <= 8'h0;
            txd_q    <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
            div_q    <= div_d;
            state_q  <= state_d;
            bit_q    <= bit_d;
            baud_q   <= baud_d;
            shift_q  <= shift_d;
            txd_q    <= txd_d;
        end
    end
endmodule

// File: tb/tb_io_uart_tx.sv
// Directed bench for io_uart_tx: register vector table plus captured-waveform frame checks.
module tb_io_uart_tx;
    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  io_addr;
    logic        io_en, io_we;
    logic [31:0] io_data_write, io_data_read;
    logic        txd, tx_busy;

    io_uart_tx #(.FIFO_DEPTH(8), .DIV_RESET(16'd868)) dut (
        .clk(clk), .reset(reset), .io_addr(io_addr), .io_en(io_en), .io_we(io_we),
        .io_data_write(io_data_write), .io_data_read(io_data_read), .txd(txd), .tx_busy(tx_busy)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    localparam int LOGN = 16384;
    logic txd_log [LOGN];
    logic busy_log [LOGN];
    logic [7:0] exp_bytes [16];

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (cyc < LOGN) begin
        txd_log[cyc]  = txd;
        busy_log[cyc] = tx_busy;
    end

    typedef struct {
        string       name;
        logic [7:0]  addr;
        logic        we;
        logic [31:0] wdat;
        logic [31:0] exp;
    } vec_t;
    vec_t vt [14];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    // All bus tasks start and end at a falling edge.
    task automatic io_write(input logic [7:0] a, input logic [31:0] d);
        io_en = 1'b1; io_we = 1'b1; io_addr = a; io_data_write = d;
        @(negedge clk);
        io_en = 1'b0; io_we = 1'b0;
    endtask

    task automatic io_read(input logic [7:0] a, output logic [31:0] r);
        io_en = 1'b1; io_we = 1'b0; io_addr = a;
        #1 r = io_data_read;
        @(negedge clk);
        io_en = 1'b0;
    endtask

    task automatic read_chk(input string name, input logic [7:0] a, input logic [31:0] exp);
        logic [31:0] r;
        io_read(a, r);
        chk(name, r, exp);
    endtask

    task automatic wait_until(input int idx);
        int g = 0;
        while (cyc <= idx && g < 20000) begin
            @(negedge clk);
            g++;
        end
        if (g >= 20000) begin
            tests++; fails++;
            $display("FAIL wait_timeout: cycle %0d required %0d", cyc, idx);
        end
    endtask

    // Frames of exp_bytes[0..nb-1] expected from log index start; idle high before and after.
    task automatic check_frames(input string name, input int start, input int div, input int nb);
        int fl, endi, errs, bad, j, k;
        logic et, eb, gt, gb;
        fl = 10 * div;
        endi = start + nb * fl;
        wait_until(endi + 1);
        errs = 0; bad = -1; gt = 1'b0; gb = 1'b0; et = 1'b0; eb = 1'b0;
        for (int i = start - 1; i <= endi; i++) begin
            logic t, b;
            if (i == start - 1 || i == endi) begin
                t = 1'b1; b = 1'b0;
            end else begin
                j = i - start;
                k = (j % fl) / div;
                b = 1'b1;
                if (k == 0)      t = 1'b0;
                else if (k == 9) t = 1'b1;
                else             t = exp_bytes[j / fl][k - 1];
            end
            if (txd_log[i] !== t || busy_log[i] !== b) begin
                if (errs == 0) begin
                    bad = i - start; gt = txd_log[i]; gb = busy_log[i]; et = t; eb = b;
                end
                errs++;
            end
        end
        tests++;
        if (errs != 0) begin
            fails++;
            $display("FAIL %s: %0d bad cycles, first at offset %0d got txd=%b busy=%b expected txd=%b busy=%b",
                     name, errs, bad, gt, gb, et, eb);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c, r, n;
        logic [31:0] rv;
        vt[0]  = '{"status_reset", 8'h04, 1'b0, 32'h0,        32'h0000_0002};
        vt[1]  = '{"div_reset",    8'h08, 1'b0, 32'h0,        32'h0000_0364};
        vt[2]  = '{"txdata_read",  8'h00, 1'b0, 32'h0,        32'h0};
        vt[3]  = '{"reg0c_read",   8'h0C, 1'b0, 32'h0,        32'h0};
        vt[4]  = '{"div_wr7",      8'h08, 1'b1, 32'hABCD0007, 32'h0};
        vt[5]  = '{"div_rd7",      8'h08, 1'b0, 32'h0,        32'h0000_0007};
        vt[6]  = '{"div_wr0",      8'h08, 1'b1, 32'h0,        32'h0};
        vt[7]  = '{"div_zero_is1", 8'h08, 1'b0, 32'h0,        32'h0000_0001};
        vt[8]  = '{"wr40",         8'h40, 1'b1, 32'h11,       32'h0};
        vt[9]  = '{"wr0c",         8'h0C, 1'b1, 32'h22,       32'h0};
        vt[10] = '{"w1c_noovf",    8'h04, 1'b1, 32'hFFFFFFFF, 32'h0};
        vt[11] = '{"status_ign",   8'h04, 1'b0, 32'h0,        32'h0000_0002};
        vt[12] = '{"read40",       8'h40, 1'b0, 32'h0,        32'h0};
        vt[13] = '{"read48",       8'h48, 1'b0, 32'h0,        32'h0};

        reset = 1'b1; io_en = 1'b0; io_we = 1'b0; io_addr = 8'h0; io_data_write = 32'h0;
        repeat (3) @(negedge clk);
        chk("txd_in_reset", {31'h0, txd}, 32'h1);
        chk("busy_in_reset", {31'h0, tx_busy}, 32'h0);
        reset = 1'b0;
        @(negedge clk);
        io_addr = 8'h08; #1;
        chk("read_no_en", io_data_read, 32'h0);
        @(negedge clk);

        for (int i = 0; i < 14; i++) begin
            if (vt[i].we) io_write(vt[i].addr, vt[i].wdat);
            else          read_chk(vt[i].name, vt[i].addr, vt[i].exp);
        end
        repeat (20) @(negedge clk);
        chk("txd_idle", {31'h0, txd}, 32'h1);

        // BAUDDIV is 1 from the table: 0x0F frame in 10 clocks.
        exp_bytes[0] = 8'h0F;
        c = cyc;
        io_write(8'h00, 32'h0F);
        check_frames("frame_div1_0f", c + 2, 1, 1);

        // 0x55 at BAUDDIV=4; busy exactly 40 clocks.
        io_write(8'h08, 32'd4);
        exp_bytes[0] = 8'h55;
        c = cyc;
        io_write(8'h00, 32'h55);
        check_frames("frame_div4_55", c + 2, 4, 1);
        n = 0;
        for (int i = c; i < c + 60; i++) if (busy_log[i] === 1'b1) n++;
        chk("busy_clocks", n, 32'd40);
        read_chk("status_after_55", 8'h04, 32'h0000_0002);

        // Back-to-back pair at BAUDDIV=2, no idle gap.
        io_write(8'h08, 32'd2);
        exp_bytes[0] = 8'h41; exp_bytes[1] = 8'h42;
        c = cyc;
        io_write(8'h00, 32'h41);
        io_write(8'h00, 32'h42);
        check_frames("frames_41_42", c + 2, 2, 2);

        // Overflow: ten pushes at depth 8, first already popped, tenth dropped.
        io_write(8'h08, 32'd100);
        c = cyc;
        for (int i = 0; i < 10; i++) begin
            if (i < 9) exp_bytes[i] = 8'h30 + 8'(i);
            io_write(8'h00, 32'h30 + i);
        end
        read_chk("status_overflow", 8'h04, 32'h0000_080D);
        io_write(8'h04, 32'h8);
        read_chk("status_w1c", 8'h04, 32'h0000_0805);
        check_frames("frames_9_in_order", c + 2, 100, 9);
        read_chk("status_drained", 8'h04, 32'h0000_0002);

        // Reset during DATA of 0xA5 (offset 8..11 carries data bit1 = 0).
        io_write(8'h08, 32'd4);
        c = cyc;
        io_write(8'h00, 32'hA5);
        io_write(8'h00, 32'h3C);
        wait_until(c + 9);
        chk("txd_before_reset", {31'h0, txd}, 32'h0);
        reset = 1'b1;
        #1;
        chk("txd_async_reset", {31'h0, txd}, 32'h1);
        chk("busy_async_reset", {31'h0, tx_busy}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        r = cyc;
        read_chk("status_post_reset", 8'h04, 32'h0000_0002);
        read_chk("div_post_reset", 8'h08, 32'h0000_0364);
        wait_until(r + 60);
        n = 0;
        for (int i = r; i < r + 60; i++) if (txd_log[i] !== 1'b1 || busy_log[i] !== 1'b0) n++;
        chk("no_residual_frame", n, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
